// File: rtl/aes_load_ctrl_if.sv
// Byte-pair load channel between the host/UART front end and aes_load_ctrl.
// The host drives the byte pair and key-size mode; the controller returns in_ready.
interface aes_load_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] state_in;
  logic [7:0] state_in2;
  logic [1:0] mod;

  modport master (
    output in_valid,
    output state_in,
    output state_in2,
    output mod,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  state_in,
    input  state_in2,
    input  mod,
    output in_ready
  );
endinterface

// File: rtl/aes_load_ctrl.sv
// Packs byte-serial plaintext/key pairs MSB-first into the AES block and key
// registers, starts the core, and holds both registers until the core is done.
module aes_load_ctrl (
  input  logic                clk,
  input  logic                rst,
  aes_load_ctrl_if.slave      host,
  input  logic                core_done,
  output logic                core_start,
  output logic [127:0]        state_out,
  output logic [255:0]        key_out,
  output logic [1:0]          key_mode,
  output logic                busy,
  output logic                err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT
  } state_e;

  state_e         state_q, state_d;
  logic [4:0]     cnt_q, cnt_d;
  logic [127:0]   state_out_q, state_out_d;
  logic [255:0]   key_out_q, key_out_d;
  logic [1:0]     key_mode_q, key_mode_d;
  logic           core_start_q, core_start_d;
  logic           err_q, err_d;

  logic           accept;
  logic [4:0]     last_idx;
  logic           last_byte;

  assign host.in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
  assign busy          = (state_q != ST_IDLE);
  assign accept        = host.in_valid && host.in_ready;

  always_comb begin
    case (key_mode_q)
      2'd1:    last_idx = 5'd23;
      2'd2:    last_idx = 5'd31;
      default: last_idx = 5'd15;
    endcase
  end

  assign last_byte = (cnt_q == last_idx);

  // Byte k lands at bit offset 8*(15-k) / 8*(31-k), i.e. the bitwise inverse of k.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    state_out_d  = state_out_q;
    key_out_d    = key_out_q;
    key_mode_d   = key_mode_q;
    core_start_d = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (host.mod == 2'd3) begin
            err_d = 1'b1;
          end else begin
            key_mode_d  = host.mod;
            state_out_d = {host.state_in, 120'd0};
            key_out_d   = {host.state_in2, 248'd0};
            cnt_d       = 5'd1;
            state_d     = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (!cnt_q[4]) begin
            state_out_d[{~cnt_q[3:0], 3'b000} +: 8] = host.state_in;
          end
          key_out_d[{~cnt_q, 3'b000} +: 8] = host.state_in2;
          if (last_byte) begin
            cnt_d        = 5'd0;
            core_start_d = 1'b1;
            state_d      = ST_START;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 5'd0;
      state_out_q  <= 128'd0;
      key_out_q    <= 256'd0;
      key_mode_q   <= 2'd0;
      core_start_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      state_out_q  <= state_out_d;
      key_out_q    <= key_out_d;
      key_mode_q   <= key_mode_d;
      core_start_q <= core_start_d;
      err_q        <= err_d;
    end
  end

  assign core_start = core_start_q;
  assign state_out  = state_out_q;
  assign key_out    = key_out_q;
  assign key_mode   = key_mode_q;
  assign err        = err_q;

endmodule

// File: tb/tb_aes_load_ctrl.sv
// Scoreboard bench for aes_load_ctrl: expected block/key/mode are queued when a
// load is driven and compared when core_start is observed.
module tb_aes_load_ctrl;

  logic         clk;
  logic         rst;
  logic         core_done;
  logic         core_start;
  logic [127:0] state_out;
  logic [255:0] key_out;
  logic [1:0]   key_mode;
  logic         busy;
  logic         err;

  aes_load_ctrl_if ifc ();

  aes_load_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .host       (ifc.slave),
    .core_done  (core_done),
    .core_start (core_start),
    .state_out  (state_out),
    .key_out    (key_out),
    .key_mode   (key_mode),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] st;
    logic [255:0] ky;
    logic [1:0]   md;
  } exp_t;

  exp_t       sb[$];
  exp_t       exp_cur;
  int         total = 0;
  int         bad   = 0;
  logic       prev_start = 1'b0;
  logic [7:0] pt_b  [32];
  logic [7:0] key_b [32];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer plus pulse-shape checks, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (prev_start) chk("start_width", 256'(core_start), 256'(0));
    if (err) chk("err_excl", 256'(core_start), 256'(0));
    if (core_start) begin
      chk("sb_level", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_state", 256'(state_out), 256'(e.st));
        chk("sb_key", key_out, e.ky);
        chk("sb_mode", 256'(key_mode), 256'(e.md));
      end
    end
    prev_start = core_start;
  end

  task automatic run_load(input logic [1:0] m, input bit gap, input int mod_sw);
    int   n;
    exp_t e;
    n    = (m == 2'd0) ? 16 : (m == 2'd1) ? 24 : 32;
    e.st = '0;
    e.ky = '0;
    e.md = m;
    for (int k = 0; k < 16; k++) e.st[127 - 8*k -: 8] = pt_b[k];
    for (int k = 0; k < n; k++)  e.ky[255 - 8*k -: 8] = key_b[k];
    sb.push_back(e);
    exp_cur = e;
    for (int k = 0; k < n; k++) begin
      ifc.in_valid  = 1'b1;
      ifc.state_in  = pt_b[k];
      ifc.state_in2 = key_b[k];
      ifc.mod       = (mod_sw >= 0 && k > mod_sw) ? 2'd0 : m;
      chk("ready_load", 256'(ifc.in_ready), 256'(1));
      @(posedge clk); #1;
      if (k < n - 1) begin
        chk("early_start", 256'(core_start), 256'(0));
        if (gap) begin
          ifc.in_valid = 1'b0;
          @(posedge clk); #1;
          chk("gap_start", 256'(core_start), 256'(0));
        end
      end
    end
    ifc.in_valid = 1'b0;
    chk("start_lat", 256'(core_start), 256'(1));
    chk("ready_start", 256'(ifc.in_ready), 256'(0));
  endtask

  task automatic finish_block();
    repeat (3) begin
      @(posedge clk); #1;
      chk("wait_ready", 256'(ifc.in_ready), 256'(0));
      chk("wait_busy", 256'(busy), 256'(1));
      chk("hold_state", 256'(state_out), 256'(exp_cur.st));
      chk("hold_key", key_out, exp_cur.ky);
    end
    core_done = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0;
    chk("done_ready", 256'(ifc.in_ready), 256'(1));
    chk("done_busy", 256'(busy), 256'(0));
    chk("done_hold_key", key_out, exp_cur.ky);
  endtask

  initial begin
    rst           = 1'b1;
    core_done     = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.state_in  = 8'd0;
    ifc.state_in2 = 8'd0;
    ifc.mod       = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 256'(state_out), 256'(0));
    chk("rst_key", key_out, 256'(0));
    chk("rst_mode", 256'(key_mode), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_start", 256'(core_start), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_ready", 256'(ifc.in_ready), 256'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    // AES-128, back to back
    for (int k = 0; k < 32; k++) begin
      pt_b[k]  = 8'(k);
      key_b[k] = 8'(8'h10 + k);
    end
    run_load(2'd0, 1'b0, -1);
    chk("k128_low", 256'(key_out[127:0]), 256'(0));
    chk("k128_key", key_out, {128'h101112131415161718191a1b1c1d1e1f, 128'd0});
    chk("k128_state", 256'(state_out), 256'(128'h000102030405060708090a0b0c0d0e0f));
    finish_block();

    // AES-256 with in_valid toggling
    for (int k = 0; k < 32; k++) begin
      pt_b[k]  = 8'(8'h40 + 3*k);
      key_b[k] = 8'(8'hA0 + k);
    end
    run_load(2'd2, 1'b1, -1);
    finish_block();

    // AES-192, mod switched to 0 after byte 3
    for (int k = 0; k < 32; k++) begin
      pt_b[k]  = 8'(8'h30 + k);
      key_b[k] = 8'(8'h60 + 5*k);
    end
    run_load(2'd1, 1'b0, 3);
    chk("k192_mode", 256'(key_mode), 256'(1));
    chk("k192_low", 256'(key_out[63:0]), 256'(0));
    finish_block();

    // reserved mode offered in IDLE
    ifc.mod       = 2'd3;
    ifc.state_in  = 8'hFF;
    ifc.state_in2 = 8'hEE;
    ifc.in_valid  = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    chk("err_pulse", 256'(err), 256'(1));
    chk("err_busy", 256'(busy), 256'(0));
    chk("err_ready", 256'(ifc.in_ready), 256'(1));
    chk("err_state", 256'(state_out), 256'(exp_cur.st));
    chk("err_key", key_out, exp_cur.ky);
    chk("err_mode", 256'(key_mode), 256'(exp_cur.md));
    @(posedge clk); #1;
    chk("err_once", 256'(err), 256'(0));
    chk("err_busy2", 256'(busy), 256'(0));

    // reset after the 10th byte of an AES-128 load
    for (int k = 0; k < 10; k++) begin
      ifc.in_valid  = 1'b1;
      ifc.state_in  = 8'(8'hC0 + k);
      ifc.state_in2 = 8'(8'hD0 + k);
      ifc.mod       = 2'd0;
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    chk("partial_busy", 256'(busy), 256'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_state", 256'(state_out), 256'(0));
    chk("mrst_key", key_out, 256'(0));
    chk("mrst_mode", 256'(key_mode), 256'(0));
    chk("mrst_busy", 256'(busy), 256'(0));
    chk("mrst_ready", 256'(ifc.in_ready), 256'(1));
    chk("mrst_start", 256'(core_start), 256'(0));
    repeat (3) begin
      @(posedge clk); #1;
      chk("mrst_no_start", 256'(core_start), 256'(0));
    end
    for (int k = 0; k < 32; k++) begin
      pt_b[k]  = 8'(7*k + 1);
      key_b[k] = 8'(8'hF0 - k);
    end
    run_load(2'd0, 1'b0, -1);
    finish_block();

    // core_done held high through START
    for (int k = 0; k < 32; k++) begin
      pt_b[k]  = 8'($urandom_range(0, 255));
      key_b[k] = 8'($urandom_range(0, 255));
    end
    core_done = 1'b1;
    run_load(2'd0, 1'b0, -1);
    @(posedge clk); #1;
    chk("hold_done_wait_busy", 256'(busy), 256'(1));
    chk("hold_done_wait_ready", 256'(ifc.in_ready), 256'(0));
    chk("hold_done_start_w", 256'(core_start), 256'(0));
    @(posedge clk); #1;
    chk("hold_done_exit_ready", 256'(ifc.in_ready), 256'(1));
    chk("hold_done_exit_busy", 256'(busy), 256'(0));
    core_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    chk("sb_drained", 256'(sb.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
